// File: rtl/byte_mem_ctrl.sv
// Byte-addressed little-endian data memory behind a valid/ready request/response port.
// Per-byte write strobes, programmable access latency, range/alignment error reporting.
module byte_mem_ctrl #(
    parameter int W      = 4,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8,
    parameter int LAT    = 2,
    parameter int ALIGN  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [8*W-1:0]    req_wdata_i,
    input  logic [W-1:0]      req_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [8*W-1:0]    rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int MA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [8*W-1:0]    wdata_q;
    logic [W-1:0]      wstrb_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [8*W-1:0]    rsp_rdata_q;
    logic              rsp_err_q;
    logic [7:0]        mem_q [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic              use_in;
    logic              a_write;
    logic [ADDR_W-1:0] a_addr;
    logic [8*W-1:0]    a_wdata;
    logic [W-1:0]      a_wstrb;
    logic [ADDR_W:0]   a_end;
    logic              a_err;
    logic [8*W-1:0]    rd_word;

    function automatic logic [MA_W-1:0] bidx(input logic [ADDR_W-1:0] a, input int i);
        return MA_W'({1'b0, a} + (ADDR_W+1)'(i));
    endfunction

    assign accept     = (state_q == IDLE) && req_valid_i && req_ready_q;
    assign enter_resp = (LAT == 1) ? accept : ((state_q == WAIT) && (cnt_q == CNT_W'(1)));

    // With LAT = 1 the access happens on the accept edge, so it must see the live request.
    assign use_in  = (state_q == IDLE);
    assign a_write = use_in ? req_write_i : wr_q;
    assign a_addr  = use_in ? req_addr_i  : addr_q;
    assign a_wdata = use_in ? req_wdata_i : wdata_q;
    assign a_wstrb = use_in ? req_wstrb_i : wstrb_q;

    // One extra bit on the end address so accesses near the top never wrap back in range.
    assign a_end = {1'b0, a_addr} + (ADDR_W+1)'(W);
    assign a_err = (a_end > (ADDR_W+1)'(DEPTH)) ||
                   ((ALIGN != 0) && ((a_addr % ADDR_W'(W)) != '0));

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < W; i++)
            rd_word[8*i +: 8] = mem_q[bidx(a_addr, i)];
    end

    always_ff @(posedge clk) begin
        if (enter_resp && a_write && !a_err)
            for (int i = 0; i < W; i++)
                if (a_wstrb[i])
                    mem_q[bidx(a_addr, i)] <= a_wdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (enter_resp) begin
                state_q     <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= a_err;
                rsp_rdata_q <= (!a_write && !a_err) ? rd_word : '0;
            end
            case (state_q)
                IDLE: begin
                    req_ready_q <= !accept;
                    if (accept) begin
                        wr_q    <= req_write_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        wstrb_q <= req_wstrb_i;
                        if (LAT != 1) begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    if (!enter_resp)
                        cnt_q <= cnt_q - 1'b1;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
